// File: rtl/scope_capture_pkg.sv
// scope_capture_pkg: shared state encodings and mode/edge constants for the capture engine
package scope_capture_pkg;
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRE   = 3'd1,
      S_ARMED = 3'd2,
      S_POST  = 3'd3,
      S_DONE  = 3'd4
   } state_t;
   localparam logic [1:0] MODE_AUTO   = 2'b00;
   localparam logic [1:0] MODE_SINGLE = 2'b10;
   localparam logic       EDGE_FALL   = 1'b1;
endpackage

// File: rtl/scope_capture_dpram.sv
// scope_capture_dpram: simple dual-port RAM, one write port and one registered read port
// Ports: clk, rst_n (clears only the read register); we/waddr/wdata write port;
//  raddr/rdata read port with 1-cycle latency.
module scope_capture_dpram #(
   parameter int W  = 24,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [2**AW];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata <= '0;
      else rdata <= mem[raddr];
   end
endmodule

// File: rtl/scope_capture.sv
// scope_capture: N-channel triggered capture engine with double-buffered frame RAM
// Ports: clk/rst_n clock and async active-low reset; sample_valid/sample_data ADC readings;
//  decim_sel keeps 1 of 2**decim_sel samples; trig_ch/trig_level/trig_edge trigger setup;
//  mode auto/normal/single; arm re-arms single mode; hold freezes the displayed frame;
//  pretrig samples kept before trigger; rd_addr/rd_data display read (1-cycle latency);
//  cap_state FSM state; frame_swap and triggered one-cycle pulses.
module scope_capture
   import scope_capture_pkg::*;
#(
   parameter int NCH     = 2,
   parameter int DW      = 12,
   parameter int DEPTH   = 1024,
   parameter int DECW    = 5,
   parameter int AUTO_TO = 4096,
   localparam int AW     = $clog2(DEPTH),
   localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_valid,
   input  logic [NCH*DW-1:0] sample_data,
   input  logic [DECW-1:0]   decim_sel,
   input  logic [CW-1:0]     trig_ch,
   input  logic [DW-1:0]     trig_level,
   input  logic              trig_edge,
   input  logic [1:0]        mode,
   input  logic              arm,
   input  logic              hold,
   input  logic [AW-1:0]     pretrig,
   input  logic [AW-1:0]     rd_addr,
   output logic [NCH*DW-1:0] rd_data,
   output logic [2:0]        cap_state,
   output logic              frame_swap,
   output logic              triggered
);
   localparam int TW = $clog2(AUTO_TO + 1);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE  = (AW+1)'(1);
   state_t          state;
   logic            disp_bank, prev_v, acc, hit, trig, we, restart;
   logic [AW-1:0]   wr_ptr, pre_l, start, disp_start;
   logic [AW:0]     cnt, post_n;
   logic [1:0]      mode_l;
   logic [DW-1:0]   prev, cur;
   logic [TW-1:0]   to_cnt;
   logic [31:0]     dec_cnt;
   assign cur       = sample_data[int'(trig_ch)*DW +: DW];
   // >= rather than == so a smaller decim_sel takes effect without waiting for a wrap
   assign acc       = sample_valid && (dec_cnt >= (32'd1 << decim_sel) - 32'd1);
   assign hit       = prev_v && ((trig_edge == EDGE_FALL) ? (prev >= trig_level && cur < trig_level)
                                                          : (prev < trig_level && cur >= trig_level));
   assign trig      = hit || (mode_l == MODE_AUTO && to_cnt == TW'(AUTO_TO - 1));
   assign post_n    = FULL - {1'b0, pre_l};
   assign we        = acc && (state == S_ARMED || state == S_POST || (state == S_PRE && cnt != {1'b0, pre_l}));
   // every frame start (from IDLE or straight after DONE) re-latches mode and pretrig
   assign restart   = (state == S_IDLE && ((mode == MODE_SINGLE) ? arm : !hold)) ||
                      (state == S_DONE && mode_l != MODE_SINGLE);
   assign cap_state = state;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         disp_bank  <= 1'b0;
         wr_ptr     <= '0;
         pre_l      <= '0;
         start      <= '0;
         disp_start <= '0;
         cnt        <= '0;
         mode_l     <= '0;
         prev       <= '0;
         prev_v     <= 1'b0;
         to_cnt     <= '0;
         dec_cnt    <= '0;
         frame_swap <= 1'b0;
         triggered  <= 1'b0;
      end else begin
         frame_swap <= 1'b0;
         triggered  <= 1'b0;
         if (sample_valid) dec_cnt <= acc ? '0 : dec_cnt + 32'd1;
         if (we) begin
            wr_ptr <= wr_ptr + 1'b1;
            prev   <= cur;
            prev_v <= 1'b1;
         end
         case (state)
            S_IDLE: if (restart) state <= S_PRE;
            S_PRE: begin
               // cnt counts pre-trigger fill here and post-trigger samples in POST
               if (cnt == {1'b0, pre_l}) state <= S_ARMED;
               else if (acc) begin
                  cnt <= cnt + ONE;
                  if (cnt + ONE == {1'b0, pre_l}) state <= S_ARMED;
               end
            end
            S_ARMED: if (acc) begin
               to_cnt <= to_cnt + 1'b1;
               if (trig) begin
                  start     <= wr_ptr - pre_l;
                  triggered <= 1'b1;
                  cnt       <= ONE;
                  state     <= (post_n == ONE) ? S_DONE : S_POST;
               end
            end
            S_POST: if (acc) begin
               cnt <= cnt + ONE;
               if (cnt + ONE == post_n) state <= S_DONE;
            end
            S_DONE: begin
               if (!hold) begin
                  disp_bank  <= ~disp_bank;
                  disp_start <= start;
                  frame_swap <= 1'b1;
               end
               state <= (mode_l == MODE_SINGLE) ? S_IDLE : S_PRE;
            end
            default: state <= S_IDLE;
         endcase
         if (restart) begin
            mode_l <= mode;
            pre_l  <= pretrig;
            wr_ptr <= '0;
            cnt    <= '0;
            prev_v <= 1'b0;
            to_cnt <= '0;
         end
      end
   end
   scope_capture_dpram #(.W(NCH*DW), .AW(AW+1)) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .waddr ({~disp_bank, wr_ptr}),
      .wdata (sample_data),
      .raddr ({disp_bank, disp_start + rd_addr}),
      .rdata (rd_data)
   );
endmodule

// File: tb/tb_scope_capture.sv
// tb_scope_capture: directed self-checking bench for scope_capture (NCH=2, DW=12, DEPTH=16, AUTO_TO=32)
module tb_scope_capture;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sample_valid;
   logic [23:0] sample_data;
   logic [4:0]  decim_sel;
   logic        trig_ch;
   logic [11:0] trig_level;
   logic        trig_edge;
   logic [1:0]  mode;
   logic        arm, hold;
   logic [3:0]  pretrig, rd_addr;
   logic [23:0] rd_data;
   logic [2:0]  cap_state;
   logic        frame_swap, triggered;
   int checks = 0, errors = 0, swaps = 0, trigs = 0, sw0 = 0, tr0 = 0;
   always #10 clk = ~clk;
   scope_capture #(.NCH(2), .DW(12), .DEPTH(16), .DECW(5), .AUTO_TO(32)) dut (
      .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
      .decim_sel(decim_sel), .trig_ch(trig_ch), .trig_level(trig_level), .trig_edge(trig_edge),
      .mode(mode), .arm(arm), .hold(hold), .pretrig(pretrig), .rd_addr(rd_addr),
      .rd_data(rd_data), .cap_state(cap_state), .frame_swap(frame_swap), .triggered(triggered)
   );
   always @(negedge clk) begin
      if (frame_swap) swaps++;
      if (triggered) trigs++;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sample_valid = 1'b0;
      end
   endtask
   task automatic put(input logic [11:0] c1, input logic [11:0] c0);
      @(negedge clk);
      sample_valid = 1'b1;
      sample_data  = {c1, c0};
   endtask
   task automatic ramp(input int off, input int a, input int b);
      for (int i = a; i <= b; i++) put(12'd0, 12'(off + 100 * i));
   endtask
   task automatic rd_check(input string tag, input logic [3:0] a, input logic [23:0] exp);
      @(negedge clk);
      rd_addr = a;
      @(negedge clk);
      check(tag, 32'(rd_data), 32'(exp));
   endtask
   task automatic pulse_arm();
      @(negedge clk);
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
   endtask
   task automatic restart(input logic [1:0] m, input logic [3:0] pt, input logic [11:0] lvl,
                          input logic e, input logic ch, input logic [4:0] d);
      @(negedge clk);
      rst_n = 1'b0;
      sample_valid = 1'b0;
      mode = m; pretrig = pt; trig_level = lvl; trig_edge = e; trig_ch = ch; decim_sel = d;
      hold = 1'b0; arm = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(2);
      sw0 = swaps;
      tr0 = trigs;
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end
   initial begin
      sample_valid = 1'b0; sample_data = '0; decim_sel = '0; trig_ch = 1'b0; trig_level = 12'd2000;
      trig_edge = 1'b0; mode = 2'b01; arm = 1'b0; hold = 1'b0; pretrig = 4'd4; rd_addr = '0;
      idle(3);
      check("rst_state", 32'(cap_state), 0);
      check("rst_rd_data", 32'(rd_data), 0);
      check("rst_swap", 32'(frame_swap), 0);
      check("rst_trig", 32'(triggered), 0);
      rst_n = 1'b1;
      idle(2);
      check("t1_pre", 32'(cap_state), 1);
      ramp(0, 0, 19); idle(2);
      check("t1_no_trig_yet", 32'(trigs), 0);
      ramp(0, 20, 20); idle(3);
      check("t1_trig_2000", 32'(trigs), 1);
      ramp(0, 21, 30); idle(3);
      check("t1_no_swap_11_post", 32'(swaps), 0);
      ramp(0, 31, 31); idle(3);
      check("t1_swap_12_post", 32'(swaps), 1);
      check("t1_state_pre", 32'(cap_state), 1);
      rd_check("t1_rd4", 4'd4, {12'd0, 12'd2000});
      rd_check("t1_rd0", 4'd0, {12'd0, 12'd1600});
      rd_check("t1_rd15", 4'd15, {12'd0, 12'd3100});
      restart(2'b00, 4'd4, 12'd2000, 1'b0, 1'b0, 5'd0);
      for (int i = 0; i < 35; i++) put(12'd0, 12'd500);
      idle(3);
      check("t2_no_auto_yet", 32'(trigs - tr0), 0);
      put(12'd0, 12'd500); idle(3);
      check("t2_auto_trig", 32'(trigs - tr0), 1);
      for (int i = 0; i < 11; i++) put(12'd0, 12'd500);
      idle(3);
      check("t2_auto_swap", 32'(swaps - sw0), 1);
      for (int a = 0; a < 16; a++) rd_check("t2_rd_500", 4'(a), {12'd0, 12'd500});
      restart(2'b01, 4'd4, 12'd2000, 1'b0, 1'b0, 5'd0);
      for (int i = 0; i < 1000; i++) put(12'd0, 12'd500);
      idle(3);
      check("t2_normal_no_swap", 32'(swaps - sw0), 0);
      check("t2_normal_armed", 32'(cap_state), 2);
      restart(2'b01, 4'd12, 12'd70, 1'b0, 1'b0, 5'd3);
      for (int i = 0; i <= 73; i++) begin
         if (i == 64) decim_sel = 5'd0;
         put(12'd0, 12'(i));
      end
      idle(3);
      check("t3_swap", 32'(swaps - sw0), 1);
      rd_check("t3_rd0", 4'd0, {12'd0, 12'd23});
      rd_check("t3_rd1", 4'd1, {12'd0, 12'd31});
      rd_check("t3_rd5", 4'd5, {12'd0, 12'd63});
      rd_check("t3_rd6", 4'd6, {12'd0, 12'd64});
      rd_check("t3_rd12", 4'd12, {12'd0, 12'd70});
      rd_check("t3_rd15", 4'd15, {12'd0, 12'd73});
      restart(2'b10, 4'd0, 12'd2000, 1'b0, 1'b0, 5'd0);
      put(12'd0, 12'd1000); put(12'd0, 12'd3000); idle(3);
      check("t4_idle_unarmed", 32'(cap_state), 0);
      check("t4_no_trig_unarmed", 32'(trigs - tr0), 0);
      pulse_arm(); idle(2);
      check("t4_armed_pretrig0", 32'(cap_state), 2);
      put(12'd0, 12'd2500); put(12'd0, 12'd1500); put(12'd0, 12'd1900); idle(3);
      check("t4_no_first_trig", 32'(trigs - tr0), 0);
      put(12'd0, 12'd2100); idle(3);
      check("t4_trig", 32'(trigs - tr0), 1);
      for (int i = 1; i <= 15; i++) put(12'd0, 12'(2100 + i));
      idle(3);
      check("t4_swap1", 32'(swaps - sw0), 1);
      check("t4_back_idle", 32'(cap_state), 0);
      rd_check("t4_rd0", 4'd0, {12'd0, 12'd2100});
      rd_check("t4_rd15", 4'd15, {12'd0, 12'd2115});
      for (int i = 0; i < 20; i++) put(12'd0, (i % 2 == 0) ? 12'd1000 : 12'd3000);
      idle(3);
      check("t4_no_rearm_swap", 32'(swaps - sw0), 1);
      pulse_arm(); idle(2);
      put(12'd0, 12'd1000); put(12'd0, 12'd1500); put(12'd0, 12'd2200);
      for (int i = 1; i <= 15; i++) put(12'd0, 12'(2200 + i));
      idle(3);
      check("t4_swap2", 32'(swaps - sw0), 2);
      rd_check("t4_rd0_second", 4'd0, {12'd0, 12'd2200});
      for (int i = 0; i < 20; i++) put(12'd0, (i % 2 == 0) ? 12'd1000 : 12'd3000);
      idle(3);
      check("t4_only_one_more", 32'(swaps - sw0), 2);
      restart(2'b01, 4'd4, 12'd2000, 1'b0, 1'b0, 5'd0);
      ramp(0, 0, 31); idle(3);
      check("t5_swap1", 32'(swaps - sw0), 1);
      rd_check("t5_rd4_first", 4'd4, {12'd0, 12'd2000});
      hold = 1'b1;
      ramp(50, 0, 31); idle(3);
      check("t5_hold_no_swap", 32'(swaps - sw0), 1);
      check("t5_hold_state_pre", 32'(cap_state), 1);
      rd_check("t5_rd4_held", 4'd4, {12'd0, 12'd2000});
      hold = 1'b0;
      ramp(25, 0, 31); idle(3);
      check("t5_release_swap", 32'(swaps - sw0), 2);
      rd_check("t5_rd4_new", 4'd4, {12'd0, 12'd2025});
      rd_check("t5_rd0_new", 4'd0, {12'd0, 12'd1625});
      restart(2'b01, 4'd4, 12'd2000, 1'b0, 1'b0, 5'd0);
      ramp(0, 0, 24); idle(1);
      check("t6_in_post", 32'(cap_state), 3);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t6_async_state", 32'(cap_state), 0);
      check("t6_async_rd_data", 32'(rd_data), 0);
      trig_ch = 1'b1; trig_level = 12'd1000; trig_edge = 1'b1;
      idle(2);
      rst_n = 1'b1;
      idle(2);
      sw0 = swaps;
      tr0 = trigs;
      for (int i = 0; i <= 18; i++) put(12'(1300 - 50 * i), 12'(i));
      idle(3);
      check("t6_fall_trig", 32'(trigs - tr0), 1);
      check("t6_swap", 32'(swaps - sw0), 1);
      rd_check("t6_rd4", 4'd4, {12'd950, 12'd7});
      rd_check("t6_rd0", 4'd0, {12'd1150, 12'd3});
      rd_check("t6_rd15", 4'd15, {12'd400, 12'd18});
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
